mem_bridge: RTL

MEM_BRIDGE -- requirements
Module: mem_bridge

---
 rtl/mem_bridge_if.sv | 31 +++
 rtl/mem_bridge.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_bridge_if.sv
// Core-side and external-bus signals of the memory bridge, bundled for port hookup.
// The bridge uses the slave modport; the core/bus model side uses master.
interface mem_bridge_if;
  logic        ram_r_ena_i;
  logic [31:0] ram_r_addr_i;
  logic        ram_w_ena_i;
  logic [31:0] ram_w_addr_i;
  logic [31:0] ram_w_data_i;
  logic [31:0] ram_r_data_o;
  logic        hold_o;
  logic        err_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;

  modport master (
    output ram_r_ena_i, ram_r_addr_i, ram_w_ena_i, ram_w_addr_i, ram_w_data_i,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i,
    input  ram_r_data_o, hold_o, err_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o
  );

  modport slave (
    input  ram_r_ena_i, ram_r_addr_i, ram_w_ena_i, ram_w_addr_i, ram_w_data_i,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i,
    output ram_r_data_o, hold_o, err_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o
  );
endinterface

// File: rtl/mem_bridge.sv
// Bridges single-cycle core read/write requests onto a request/grant external bus,
// stalling the core via hold_o and aborting on misalignment or timeout.
module mem_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk_100MHz,
  input  logic         arst_n,
  mem_bridge_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 32'd1);

  state_e      state_q, state_d;
  logic        pend_rd_q, pend_rd_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        hold;

  // Next-state and next-output computation for the bridge FSM.
  always_comb begin
    state_d   = state_q;
    pend_rd_d = pend_rd_q;
    cnt_d     = cnt_q;
    rd_addr_d = rd_addr_q;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    case (state_q)
      IDLE: begin
        req_d = 1'b0;
        cnt_d = 8'd0;
        if (bus.ram_w_ena_i) begin
          // A write always goes first; an accompanying read is parked in pend_rd.
          if (bus.ram_w_addr_i[1:0] != 2'b00) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d   = REQ;
            req_d     = 1'b1;
            we_d      = 1'b1;
            addr_d    = bus.ram_w_addr_i;
            wdata_d   = bus.ram_w_data_i;
            pend_rd_d = bus.ram_r_ena_i;
            rd_addr_d = bus.ram_r_addr_i;
          end
        end else if (bus.ram_r_ena_i) begin
          if (bus.ram_r_addr_i[1:0] != 2'b00) begin
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = 32'd0;
          end else begin
            state_d   = REQ;
            req_d     = 1'b1;
            we_d      = 1'b0;
            addr_d    = bus.ram_r_addr_i;
            pend_rd_d = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (bus.bus_gnt_i) begin
          cnt_d = 8'd0;
          if (we_q && pend_rd_q) begin
            pend_rd_d = 1'b0;
            if (rd_addr_q[1:0] != 2'b00) begin
              state_d = DONE;
              req_d   = 1'b0;
              err_d   = 1'b1;
              rdata_d = 32'd0;
            end else begin
              state_d = REQ;
              req_d   = 1'b1;
              we_d    = 1'b0;
              addr_d  = rd_addr_q;
            end
          end else if (we_q) begin
            state_d = DONE;
            req_d   = 1'b0;
          end else begin
            state_d = WAIT_R;
            req_d   = 1'b0;
          end
        end else if (cnt_q == TMO_LAST) begin
          state_d   = DONE;
          req_d     = 1'b0;
          err_d     = 1'b1;
          cnt_d     = 8'd0;
          pend_rd_d = 1'b0;
          if (!we_q || pend_rd_q) begin
            rdata_d = 32'd0;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT_R: begin
        req_d = 1'b0;
        if (bus.bus_rvalid_i) begin
          state_d = DONE;
          rdata_d = bus.bus_rdata_i;
          cnt_d   = 8'd0;
        end else if (cnt_q == TMO_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = 32'd0;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        req_d   = 1'b0;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d   = IDLE;
        req_d     = 1'b0;
        cnt_d     = 8'd0;
        pend_rd_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything on the edge.
  always_ff @(posedge clk_100MHz) begin
    if (!arst_n) begin
      state_q   <= IDLE;
      pend_rd_q <= 1'b0;
      cnt_q     <= 8'd0;
      rd_addr_q <= 32'd0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      pend_rd_q <= pend_rd_d;
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  // Stall must rise in the very cycle the core issues a request, so it is combinational.
  always_comb begin
    hold = 1'b0;
    if (!arst_n) begin
      hold = 1'b0;
    end else begin
      case (state_q)
        IDLE:    hold = bus.ram_r_ena_i | bus.ram_w_ena_i;
        REQ:     hold = 1'b1;
        WAIT_R:  hold = 1'b1;
        DONE:    hold = 1'b0;
        default: hold = 1'b0;
      endcase
    end
  end

  assign bus.hold_o       = hold;
  assign bus.err_o        = err_q;
  assign bus.ram_r_data_o = rdata_q;
  assign bus.bus_req_o    = req_q;
  assign bus.bus_we_o     = we_q;
  assign bus.bus_addr_o   = {addr_q[31:2], 2'b00};
  assign bus.bus_wdata_o  = wdata_q;

endmodule
